// File: rtl/core_if_fetch_ctrl.sv
// Fetch controller: serves a PC from the recent-fetch buffer on a tag hit, else reads the bus.
// Latency: hit/misalign 1 cycle, miss 2 + bus waits; a request is taken only in IDLE with no flush.
module core_if_fetch_ctrl #(
    parameter int DEPTH  = 2,
    parameter bit HIT_EN = 1'b1
) (
    input  logic                   clk,
    input  logic                   rest,
    input  logic                   req_valid,
    input  logic [31:0]            req_pc,
    output logic                   req_ready,
    input  logic                   flush,
    output logic                   resp_valid,
    output logic [31:0]            resp_pc,
    output logic [31:0]            resp_instr,
    output logic                   resp_misalign,
    output logic                   bus_read,
    output logic [31:0]            bus_addr,
    input  logic                   bus_ready,
    input  logic [31:0]            bus_rdata,
    output logic                   buf_write,
    output logic [31:0]            buf_addr,
    output logic [31:0]            buf_data,
    input  logic [DEPTH-1:0][31:0] buf_all_addr,
    input  logic [DEPTH-1:0][31:0] buf_all_data
);
    typedef enum logic [1:0] {IDLE, READ, DISCARD} state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic        resp_valid_q;
    logic        resp_misalign_q;
    logic [31:0] resp_pc_q;
    logic [31:0] resp_instr_q;
    logic        bus_read_q;
    logic [31:0] bus_addr_q;

    logic        accept;
    logic        misalign;
    logic        hit;
    logic [31:0] hit_data;
    logic        in_bus;

    assign req_ready = (state_q == IDLE) && !flush;
    assign accept    = req_valid && req_ready;
    assign misalign  = (req_pc[1:0] != 2'b00);

    // Scan from the oldest entry down so the newest (lowest index) match wins.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (buf_all_addr[i] == {1'b1, req_pc[30:0]}) begin
                hit      = 1'b1;
                hit_data = buf_all_data[i];
            end
        end
        if (!HIT_EN || req_pc[31]) begin
            hit = 1'b0;
        end
    end

    // Completed transfers always fill the buffer, even when the response is flushed.
    assign in_bus    = (state_q == READ) || (state_q == DISCARD);
    assign buf_write = in_bus && bus_ready && !pc_q[31];
    assign buf_addr  = {1'b1, pc_q[30:0]};
    assign buf_data  = bus_rdata;

    assign resp_valid    = resp_valid_q;
    assign resp_misalign = resp_misalign_q;
    assign resp_pc       = resp_pc_q;
    assign resp_instr    = resp_instr_q;
    assign bus_read      = bus_read_q;
    assign bus_addr      = bus_addr_q;

    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            state_q         <= IDLE;
            pc_q            <= '0;
            resp_valid_q    <= 1'b0;
            resp_misalign_q <= 1'b0;
            resp_pc_q       <= '0;
            resp_instr_q    <= '0;
            bus_read_q      <= 1'b0;
            bus_addr_q      <= '0;
        end else begin
            resp_valid_q    <= 1'b0;
            resp_misalign_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (misalign) begin
                            resp_valid_q    <= 1'b1;
                            resp_misalign_q <= 1'b1;
                            resp_pc_q       <= req_pc;
                            resp_instr_q    <= '0;
                        end else if (hit) begin
                            resp_valid_q <= 1'b1;
                            resp_pc_q    <= req_pc;
                            resp_instr_q <= hit_data;
                        end else begin
                            pc_q       <= req_pc;
                            bus_read_q <= 1'b1;
                            bus_addr_q <= {req_pc[31:2], 2'b00};
                            state_q    <= READ;
                        end
                    end
                end
                READ: begin
                    if (bus_ready) begin
                        bus_read_q <= 1'b0;
                        state_q    <= IDLE;
                        if (!flush) begin
                            resp_valid_q <= 1'b1;
                            resp_pc_q    <= pc_q;
                            resp_instr_q <= bus_rdata;
                        end
                    end else if (flush) begin
                        state_q <= DISCARD;
                    end
                end
                DISCARD: begin
                    if (bus_ready) begin
                        bus_read_q <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    bus_read_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_core_if_fetch_ctrl.sv
// Randomized bench for core_if_fetch_ctrl with a scoreboard, a bus responder and a model of the shift buffer.
module tb_core_if_fetch_ctrl;
    localparam int DEPTH  = 2;
    localparam bit HIT_EN = 1'b1;

    logic                   clk;
    logic                   rest;
    logic                   req_valid;
    logic [31:0]            req_pc;
    logic                   req_ready;
    logic                   flush;
    logic                   resp_valid;
    logic [31:0]            resp_pc;
    logic [31:0]            resp_instr;
    logic                   resp_misalign;
    logic                   bus_read;
    logic [31:0]            bus_addr;
    logic                   bus_ready;
    logic [31:0]            bus_rdata;
    logic                   buf_write;
    logic [31:0]            buf_addr;
    logic [31:0]            buf_data;
    logic [DEPTH-1:0][31:0] buf_all_addr;
    logic [DEPTH-1:0][31:0] buf_all_data;

    core_if_fetch_ctrl #(.DEPTH(DEPTH), .HIT_EN(HIT_EN)) dut (
        .clk(clk), .rest(rest),
        .req_valid(req_valid), .req_pc(req_pc), .req_ready(req_ready), .flush(flush),
        .resp_valid(resp_valid), .resp_pc(resp_pc), .resp_instr(resp_instr),
        .resp_misalign(resp_misalign),
        .bus_read(bus_read), .bus_addr(bus_addr), .bus_ready(bus_ready), .bus_rdata(bus_rdata),
        .buf_write(buf_write), .buf_addr(buf_addr), .buf_data(buf_data),
        .buf_all_addr(buf_all_addr), .buf_all_data(buf_all_data)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        mis;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] cached[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    int          bus_wait = 0;
    int          wcnt     = 0;
    logic [31:0] cur_pc;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] al;
        al = {a[31:2], 2'b00};
        if (al == 32'h100) return 32'h0000_0013;
        return (al * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    function automatic bit model_has(input logic [31:0] pc);
        foreach (cached[i]) if (cached[i] == pc) return 1'b1;
        return 1'b0;
    endfunction

    // Connected shift buffer: newest entry at index 0, cleared synchronously in reset.
    always @(posedge clk) begin
        if (!rest) begin
            buf_all_addr <= '0;
            buf_all_data <= '0;
        end else if (buf_write) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                buf_all_addr[i] <= buf_all_addr[i-1];
                buf_all_data[i] <= buf_all_data[i-1];
            end
            buf_all_addr[0] <= buf_addr;
            buf_all_data[0] <= buf_data;
        end
    end

    // Bus slave: bus_wait idle cycles with bus_read high, then one bus_ready cycle.
    initial begin
        bus_ready = 1'b0;
        bus_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (bus_ready || !bus_read) begin
                bus_ready = 1'b0;
                wcnt      = 0;
            end else if (wcnt >= bus_wait) begin
                bus_ready = 1'b1;
                bus_rdata = mem_word(bus_addr);
            end else begin
                wcnt++;
            end
        end
    end

    // Monitor: pops the scoreboard on every response and watches the bus/buffer side.
    always @(negedge clk) begin
        exp_t e;
        logic exp_bw;
        if (resp_valid) begin
            if (sb.size() == 0) begin
                chk("spurious_resp_valid", 32'(resp_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("resp_pc", resp_pc, e.pc);
                chk("resp_instr", resp_instr, e.instr);
                chk("resp_misalign", 32'(resp_misalign), 32'(e.mis));
                chk("resp_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
        exp_bw = bus_ready && bus_read && !cur_pc[31];
        if (buf_write || exp_bw) chk("buf_write", 32'(buf_write), 32'(exp_bw));
        if (exp_bw) begin
            chk("buf_addr", buf_addr, {1'b1, cur_pc[30:0]});
            chk("buf_data", buf_data, mem_word(cur_pc));
        end
        if (bus_read) chk("bus_addr", bus_addr, {cur_pc[31:2], 2'b00});
    end

    // Starts and ends at posedge+1; fl_at is the cycle offset of a one-cycle flush pulse.
    task automatic do_fetch(input logic [31:0] pc, input int w, input int fl_at);
        logic mis;
        logic hit;
        logic drop;
        int   lat;
        exp_t e;
        mis  = (pc[1:0] != 2'b00);
        hit  = !mis && HIT_EN && !pc[31] && model_has(pc);
        lat  = (mis || hit) ? 1 : 2 + w;
        drop = !mis && !hit && (fl_at >= 1) && (fl_at <= 1 + w);
        flush    = 1'b0;
        bus_wait = w;
        cur_pc   = pc;
        if (!drop) begin
            e.pc    = pc;
            e.instr = mis ? 32'h0 : mem_word(pc);
            e.mis   = mis;
            e.cyc   = cyc + lat;
            sb.push_back(e);
        end
        req_valid = 1'b1;
        req_pc    = pc;
        #1;
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        for (int i = 1; i <= lat; i++) begin
            @(posedge clk);
            #1;
            req_valid = 1'b0;
            flush     = (i == fl_at) && (i < lat);
            if (i == 1) chk("bus_read_after_req", 32'(bus_read), 32'(!(mis || hit)));
        end
        if (!mis && !hit && !pc[31]) begin
            cached.push_front(pc);
            if (cached.size() > DEPTH) void'(cached.pop_back());
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pc;
        int          r;
        rest = 1'b0; req_valid = 1'b0; req_pc = '0; flush = 1'b0; cur_pc = '0;
        #1;
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_misalign", 32'(resp_misalign), 32'd0);
        chk("rst_resp_pc", resp_pc, 32'd0);
        chk("rst_resp_instr", resp_instr, 32'd0);
        chk("rst_bus_read", 32'(bus_read), 32'd0);
        chk("rst_bus_addr", bus_addr, 32'd0);
        chk("rst_buf_write", 32'(buf_write), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1 rest = 1'b1;

        do_fetch(32'h100, 3, -1);
        do_fetch(32'h100, 0, -1);
        do_fetch(32'h104, 1, -1);
        do_fetch(32'h108, 0, -1);
        do_fetch(32'h100, 2, -1);
        do_fetch(32'h200, 2, 1);
        do_fetch(32'h200, 0, -1);
        do_fetch(32'h204, 1, 2);
        do_fetch(32'h204, 0, -1);
        do_fetch(32'h102, 0, -1);
        do_fetch(32'h8000_0000, 1, -1);
        do_fetch(32'h8000_0000, 0, -1);

        // A flushed request must not be taken, even one that would hit.
        flush = 1'b1; req_valid = 1'b1; req_pc = 32'h200;
        #1 chk("flush_blocks_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        chk("flush_no_bus_read", 32'(bus_read), 32'd0);
        @(posedge clk); #1;
        flush = 1'b0; req_valid = 1'b0;

        for (int i = 0; i < 6; i++) do_fetch((i % 2 == 0) ? 32'h200 : 32'h204, 0, -1);

        // Reset in the middle of a bus read.
        bus_wait = 20; cur_pc = 32'h300; req_valid = 1'b1; req_pc = 32'h300;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("mid_bus_read_up", 32'(bus_read), 32'd1);
        @(posedge clk); #3;
        rest = 1'b0;
        #1;
        chk("arst_bus_read", 32'(bus_read), 32'd0);
        chk("arst_resp_valid", 32'(resp_valid), 32'd0);
        chk("arst_buf_write", 32'(buf_write), 32'd0);
        repeat (2) @(posedge clk);
        #1 rest = 1'b1;
        cached.delete();
        chk("arst_resp_pc", resp_pc, 32'd0);
        chk("arst_bus_addr", bus_addr, 32'd0);
        do_fetch(32'h100, 1, -1);

        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 9);
            if (r <= 5)      pc = 32'h100 + 32'($urandom_range(0, 3)) * 4;
            else if (r == 6) pc = 32'h8000_0000 + 32'($urandom_range(0, 1)) * 4;
            else if (r == 7) pc = 32'h100 + 32'($urandom_range(0, 3)) * 4 + 32'($urandom_range(1, 3));
            else             pc = 32'h1000 + 32'($urandom_range(0, 63)) * 4;
            do_fetch(pc, $urandom_range(0, 3), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : -1);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end

        repeat (4) @(posedge clk);
        #1 chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
